fixed_point_multiplier: RTL and testbench

FIXED_POINT_MULTIPLIER -- requirements
Module: fixed_point_multiplier

---
 rtl/fixed_point_multiplier_pkg.sv | 21 ++
 rtl/fixed_point_multiplier_if.sv | 34 +++
 rtl/fixed_point_normalizer.sv | 70 +++++++
 rtl/fixed_point_multiplier.sv | 139 +++++++++++++
 tb/tb_fixed_point_multiplier.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fixed_point_multiplier_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (multiplier and divider).
// Contents:
//   FRAC_W      - width of a thousandths fraction field
//   FRAC_SCALE  - one integer unit expressed in thousandths
//   FRAC_MAX    - largest legal fraction value
//   ST_*        - controller state encodings
package fixed_point_multiplier_pkg;

  localparam int FRAC_W = 10;

  localparam logic [FRAC_W-1:0] FRAC_SCALE = 10'd1000;
  localparam logic [FRAC_W-1:0] FRAC_MAX   = 10'd999;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SPLIT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/fixed_point_multiplier_if.sv
// Operation bus of the fixed-point multiplier.
//   start        - request a new operation
//   m, f, b      - operand integer part, operand fraction (thousandths), multiplier
//   p_int/p_frac - product integer part and fraction (thousandths)
//   busy         - operation in progress
//   done/invalid - one-cycle completion / rejection pulses
// master: the requester; slave: the multiplier.
interface fixed_point_multiplier_if
  import fixed_point_multiplier_pkg::*;
#(
  parameter int SIZE = 4
);

  logic                start;
  logic [SIZE-1:0]     m;
  logic [FRAC_W-1:0]   f;
  logic [SIZE-1:0]     b;
  logic [2*SIZE-1:0]   p_int;
  logic [FRAC_W-1:0]   p_frac;
  logic                busy;
  logic                done;
  logic                invalid;

  modport master (
    output start, m, f, b,
    input  p_int, p_frac, busy, done, invalid
  );

  modport slave (
    input  start, m, f, b,
    output p_int, p_frac, busy, done, invalid
  );

endinterface

// File: rtl/fixed_point_normalizer.sv
// Splits a thousandths accumulator into integer and fraction parts by
// repeated subtraction of FRAC_SCALE.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   clr           - synchronous clear of the results (new operation latched)
//   start         - load acc_in and begin splitting
//   acc_in        - value to split, in thousandths
//   done          - high during the cycle whose edge completes the split
//   int_out       - registered integer part
//   frac_out      - registered fraction part, 0..FRAC_MAX
module fixed_point_normalizer
  import fixed_point_multiplier_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int INT_W = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              done,
  output logic [INT_W-1:0]  int_out,
  output logic [FRAC_W-1:0] frac_out
);

  localparam logic [ACC_W-1:0] SCALE  = ACC_W'(FRAC_SCALE);
  localparam logic [ACC_W-1:0] SCALE2 = SCALE + SCALE;

  logic [ACC_W-1:0] acc;
  logic             running;
  logic             ge_one;
  logic             ge_two;

  assign ge_one = (acc >= SCALE);
  assign ge_two = (acc >= SCALE2);

  // The final subtraction and the fraction load share one cycle, so a
  // split yielding k >= 1 integer units takes exactly k cycles (one cycle
  // when the value is already below FRAC_SCALE).
  assign done = running && !ge_two;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      running  <= 1'b0;
      int_out  <= '0;
      frac_out <= '0;
    end else if (clr) begin
      acc      <= '0;
      running  <= 1'b0;
      int_out  <= '0;
      frac_out <= '0;
    end else if (start) begin
      acc      <= acc_in;
      running  <= 1'b1;
      int_out  <= '0;
    end else if (running) begin
      if (ge_one) begin
        acc     <= acc - SCALE;
        int_out <= int_out + INT_W'(1);
      end
      if (!ge_two) begin
        running  <= 1'b0;
        frac_out <= FRAC_W'(ge_one ? (acc - SCALE) : acc);
      end
    end
  end

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential fixed-point multiplier: P = (m*1000 + f) * b computed by
// repeated addition, then split into integer and thousandths parts.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - operation bus (slave side): start/m/f/b in, p_int/p_frac/busy/done/invalid out
module fixed_point_multiplier
  import fixed_point_multiplier_pkg::*;
#(
  parameter int SIZE = 4
)(
  input  logic                        clk,
  input  logic                        rst,
  fixed_point_multiplier_if.slave     bus
);

  localparam int X_W   = SIZE + FRAC_W;
  localparam int ACC_W = 2*SIZE + FRAC_W;
  localparam int INT_W = 2*SIZE;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [SIZE-1:0]   m_r;
  logic [FRAC_W-1:0] f_r;
  logic [SIZE-1:0]   b_r;
  logic [X_W-1:0]    x_r;
  logic [SIZE-1:0]   cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              busy_r;
  logic              done_r;
  logic              invalid_r;

  logic              norm_clr;
  logic              norm_start;
  logic              norm_done;
  logic [INT_W-1:0]  norm_int;
  logic [FRAC_W-1:0] norm_frac;

  assign acc_sum = acc + ACC_W'(x_r);

  always_comb begin
    state_next = state;
    norm_clr   = 1'b0;
    norm_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_CHECK;
          norm_clr   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (f_r > FRAC_MAX) begin
          state_next = ST_ERR;
          norm_clr   = 1'b1;
        end else if ((b_r == '0) || ((m_r == '0) && (f_r == '0))) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ADD;
        end
      end
      ST_ADD: begin
        // Last addition goes straight into the normalizer, so SPLIT starts
        // on the same edge that retires the counter.
        if (cnt == SIZE'(1)) begin
          state_next = ST_SPLIT;
          norm_start = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (norm_done) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      m_r       <= '0;
      f_r       <= '0;
      b_r       <= '0;
      x_r       <= '0;
      cnt       <= '0;
      acc       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      state     <= state_next;
      busy_r    <= (state_next != ST_IDLE);
      done_r    <= (state_next == ST_DONE);
      invalid_r <= (state_next == ST_ERR);
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            m_r <= bus.m;
            f_r <= bus.f;
            b_r <= bus.b;
            acc <= '0;
          end
        end
        ST_CHECK: begin
          x_r <= X_W'(m_r) * X_W'(FRAC_SCALE) + X_W'(f_r);
          cnt <= b_r;
        end
        ST_ADD: begin
          acc <= acc_sum;
          cnt <= cnt - SIZE'(1);
        end
        default: ;
      endcase
    end
  end

  fixed_point_normalizer #(
    .ACC_W (ACC_W),
    .INT_W (INT_W)
  ) u_normalizer (
    .clk      (clk),
    .rst      (rst),
    .clr      (norm_clr),
    .start    (norm_start),
    .acc_in   (acc_sum),
    .done     (norm_done),
    .int_out  (norm_int),
    .frac_out (norm_frac)
  );

  assign bus.p_int   = norm_int;
  assign bus.p_frac  = norm_frac;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.invalid = invalid_r;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Bench for fixed_point_multiplier (SIZE=4): directed cases plus random
// operands checked against an arithmetic model of the product.
module tb_fixed_point_multiplier;

  localparam int SIZE = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fixed_point_multiplier_if #(.SIZE(SIZE)) bus ();

  fixed_point_multiplier #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.m = 4'($urandom);
    bus.f = 10'($urandom);
    bus.b = 4'($urandom);
  endtask

  // One operation from request to the cycle after its completion pulse.
  task automatic run_op(input int mi, input int fi, input int bi,
                        input bit pulse_mid, input bit hold_at_done, input string tag);
    longint p;
    int     exp_int, exp_frac, exp_lat, edges, busy_cyc;
    bit     exp_inv, lat_known;
    exp_inv = (fi > 999);
    p = longint'(mi * 1000 + fi) * longint'(bi);
    if (exp_inv) begin
      exp_int = 0; exp_frac = 0; exp_lat = 2; lat_known = 1'b1;
    end else begin
      exp_int  = int'(p / 1000);
      exp_frac = int'(p % 1000);
      if (bi == 0 || (mi == 0 && fi == 0)) begin
        exp_lat = 2; lat_known = 1'b1;
      end else begin
        exp_lat   = bi + exp_int + 2;
        lat_known = (exp_int > 0);
      end
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.m = mi[SIZE-1:0];
    bus.f = fi[9:0];
    bus.b = bi[SIZE-1:0];
    @(posedge clk);
    edges = 1;
    #1;
    bus.start = 1'b0;
    scramble();
    @(negedge clk);
    check({tag, ".busy_start"}, bus.busy, 1);
    check({tag, ".p_int_clr"}, bus.p_int, 0);
    check({tag, ".p_frac_clr"}, bus.p_frac, 0);
    busy_cyc = 0;
    while (!(bus.done || bus.invalid) && edges < 400) begin
      if (bus.busy) busy_cyc++;
      bus.start = pulse_mid && (edges == 3);
      scramble();
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (bus.busy) busy_cyc++;
    check({tag, ".finished"}, bus.done | bus.invalid, 1);
    check({tag, ".done"}, bus.done, !exp_inv);
    check({tag, ".invalid"}, bus.invalid, exp_inv);
    check({tag, ".p_int"}, bus.p_int, exp_int);
    check({tag, ".p_frac"}, bus.p_frac, exp_frac);
    if (lat_known) begin
      check({tag, ".latency"}, edges, exp_lat);
      check({tag, ".busy_cycles"}, busy_cyc, exp_lat);
    end
    bus.start = hold_at_done;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".invalid_pulse"}, bus.invalid, 0);
    check({tag, ".idle_busy"}, bus.busy, 0);
    check({tag, ".p_int_hold"}, bus.p_int, exp_int);
    check({tag, ".p_frac_hold"}, bus.p_frac, exp_frac);
  endtask

  initial begin
    int pulses;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.m = '0;
    bus.f = '0;
    bus.b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.invalid", bus.invalid, 0);
    check("reset.p_int", bus.p_int, 0);
    check("reset.p_frac", bus.p_frac, 0);
    rst = 1'b1;

    run_op(2, 500, 3, 1'b0, 1'b0, "m2f500b3");
    run_op(7, 500, 2, 1'b0, 1'b0, "m7f500b2");
    run_op(9, 123, 0, 1'b0, 1'b0, "b_zero");
    run_op(0, 0, 5, 1'b0, 1'b0, "mf_zero");
    run_op(3, 1000, 4, 1'b0, 1'b0, "f1000");
    run_op(15, 999, 15, 1'b1, 1'b1, "max");
    run_op(0, 250, 2, 1'b0, 1'b0, "frac_only");

    // Reset in the middle of the ADD phase.
    @(negedge clk);
    bus.start = 1'b1;
    bus.m = 4'd15;
    bus.f = 10'd999;
    bus.b = 4'd15;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset.busy", bus.busy, 0);
    check("midreset.done", bus.done, 0);
    check("midreset.invalid", bus.invalid, 0);
    check("midreset.p_int", bus.p_int, 0);
    check("midreset.p_frac", bus.p_frac, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.invalid || bus.busy) pulses++;
    end
    check("midreset.quiet", pulses, 0);
    run_op(2, 500, 3, 1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 20; i++) begin
      int rm, rf, rb;
      rm = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rf = int'($urandom_range(1000, 1023));
      else                           rf = int'($urandom_range(0, 999));
      run_op(rm, rf, rb, 1'b0, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
